// File: rtl/nfca_tx_framer.sv
// NFC-A reader-to-card frame sequencer: SOF, LSB-first data with odd parity, optional CRC_A, EOF, RX window.
// Optional CRC_A append path is built when NFCA_TX_CRC_EN is defined.
module nfca_tx_framer #(
    parameter int unsigned RX_TIMEOUT = 1048576
) (
    input  logic       rstn,
    input  logic       clk,
    input  logic       tx_tvalid,
    output logic       tx_tready,
    input  logic [7:0] tx_tdata,
    input  logic       tx_tlast,
    input  logic [2:0] tx_tlastb,
    input  logic       tx_tcrc,
    input  logic       tx_req,
    output logic       tx_en,
    output logic       tx_bit,
    input  logic       rx_on,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    localparam int unsigned TmoW = $clog2(RX_TIMEOUT) + 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StSof, StData, StPar, StEof, StRxWait} state_e;

    state_e          state_q;
    logic [7:0]      hold_q;
    logic            hold_v_q;
    logic            hold_last_q;
    logic [3:0]      hold_nbits_q;
    logic [7:0]      shift_q;
    logic [2:0]      bit_idx_q;
    logic [3:0]      nbits_q;
    logic            cur_last_q;
    logic            par_q;
    logic            last_acc_q;
    logic            rx_on_q;
    logic            rx_seen_q;
    logic [TmoW-1:0] tmo_q;
    logic            tx_en_q, tx_bit_q, busy_q, done_q, underrun_q;

    logic       accept, ld_hold, ld_crc, ld_en, crc_more, data_end;
    logic [7:0] ld_byte;
    logic [3:0] ld_nbits;
    logic       ld_last;

`ifdef NFCA_TX_CRC_EN
    logic [15:0] crc_q;
    logic        crc_en_q;
    logic [1:0]  crc_ph_q;   // 0: user bytes, 1: CRC lo on air, 2: CRC hi on air
    logic        cur_user;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = (c >> 1) ^ ((c[0] ^ b) ? 16'h8408 : 16'h0000);
    endfunction

    assign crc_more = crc_en_q & cur_last_q & (crc_ph_q != 2'd2);
    assign cur_user = (crc_ph_q == 2'd0);
`else
    logic unused_tcrc;
    assign unused_tcrc = tx_tcrc;
    assign crc_more    = 1'b0;
`endif

    assign tx_tready = rstn & ~hold_v_q & ~last_acc_q &
                       (state_q inside {StIdle, StSof, StData, StPar});
    assign accept    = tx_tvalid & tx_tready;
    assign ld_hold   = tx_req & hold_v_q & ((state_q == StSof) | (state_q == StPar));
    assign ld_crc    = tx_req & (state_q == StPar) & ~hold_v_q & crc_more;
    assign ld_en     = ld_hold | ld_crc;
    assign data_end  = ({1'b0, bit_idx_q} == (nbits_q - 4'd1));

    always_comb begin
        ld_byte  = hold_q;
        ld_nbits = hold_nbits_q;
        ld_last  = hold_last_q;
        if (!ld_hold) begin
            ld_nbits = 4'd8;
            ld_last  = 1'b1;
`ifdef NFCA_TX_CRC_EN
            ld_byte  = (crc_ph_q == 2'd0) ? crc_q[7:0] : crc_q[15:8];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            hold_v_q     <= 1'b0;
            hold_last_q  <= 1'b0;
            hold_nbits_q <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            nbits_q      <= '0;
            cur_last_q   <= 1'b0;
            par_q        <= 1'b0;
            last_acc_q   <= 1'b0;
            rx_on_q      <= 1'b0;
            rx_seen_q    <= 1'b0;
            tmo_q        <= '0;
            tx_en_q      <= 1'b0;
            tx_bit_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef NFCA_TX_CRC_EN
            crc_q        <= 16'h6363;
            crc_en_q     <= 1'b0;
            crc_ph_q     <= 2'd0;
`endif
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            rx_on_q    <= rx_on;

            // An accept wins over a same-cycle load: the old byte moves to the shifter.
            if (accept) begin
                hold_q       <= tx_tdata;
                hold_v_q     <= 1'b1;
                hold_last_q  <= tx_tlast;
                hold_nbits_q <= (tx_tlast && tx_tlastb != 3'd0) ? {1'b0, tx_tlastb} : 4'd8;
                if (tx_tlast) last_acc_q <= 1'b1;
            end else if (ld_hold) begin
                hold_v_q <= 1'b0;
            end

            if (ld_en) begin
                shift_q    <= {1'b0, ld_byte[7:1]};
                tx_en_q    <= 1'b1;
                tx_bit_q   <= ld_byte[0];
                bit_idx_q  <= 3'd0;
                nbits_q    <= ld_nbits;
                cur_last_q <= ld_last;
                par_q      <= ~^ld_byte;
                state_q    <= StData;
`ifdef NFCA_TX_CRC_EN
                if (ld_hold) crc_q <= crc_step(crc_q, ld_byte[0]);
                if (ld_crc) crc_ph_q <= crc_ph_q + 2'd1;
`endif
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        busy_q   <= 1'b1;
                        tx_en_q  <= 1'b1;
                        tx_bit_q <= 1'b0;
                        state_q  <= StSof;
`ifdef NFCA_TX_CRC_EN
                        crc_q    <= 16'h6363;
                        crc_en_q <= tx_tcrc;
                        crc_ph_q <= 2'd0;
`endif
                    end
                end
                StData: begin
                    if (tx_req) begin
                        if (data_end) begin
                            if (nbits_q == 4'd8) begin
                                tx_bit_q <= par_q;
                                state_q  <= StPar;
                            end else begin
                                tx_en_q  <= 1'b0;
                                tx_bit_q <= 1'b0;
                                state_q  <= StEof;
                            end
                        end else begin
                            tx_bit_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
`ifdef NFCA_TX_CRC_EN
                            if (cur_user) crc_q <= crc_step(crc_q, shift_q[0]);
`endif
                        end
                    end
                end
                StPar: begin
                    if (tx_req && !ld_en) begin
                        tx_en_q    <= 1'b0;
                        tx_bit_q   <= 1'b0;
                        state_q    <= StEof;
                        underrun_q <= ~cur_last_q;
                    end
                end
                StEof: begin
                    if (tx_req) begin
                        state_q   <= StRxWait;
                        tmo_q     <= '0;
                        rx_seen_q <= 1'b0;
                    end
                end
                StRxWait: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (rx_on && !rx_on_q) rx_seen_q <= 1'b1;
                    if ((rx_seen_q && !rx_on && rx_on_q) || (tmo_q == TmoLast)) begin
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        last_acc_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_bit   = tx_bit_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_nfca_tx_framer.sv
// Self-checking bench for nfca_tx_framer: table vectors, corner sequences and random frames vs a model.
module tb_nfca_tx_framer;
    localparam int unsigned TMO = 40;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tx_tvalid = 1'b0;
    logic       tx_tready;
    logic [7:0] tx_tdata = '0;
    logic       tx_tlast = 1'b0;
    logic [2:0] tx_tlastb = '0;
    logic       tx_tcrc = 1'b0;
    logic       tx_req = 1'b0;
    logic       tx_en, tx_bit;
    logic       rx_on = 1'b0;
    logic       busy, done, underrun;

    nfca_tx_framer #(.RX_TIMEOUT(TMO)) dut (
        .rstn(rstn), .clk(clk), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tlastb(tx_tlastb), .tx_tcrc(tx_tcrc),
        .tx_req(tx_req), .tx_en(tx_en), .tx_bit(tx_bit), .rx_on(rx_on), .busy(busy),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] f_data[8];
    logic [2:0] f_lastb[8];
    bit         f_last[8];
    int         f_n;
    bit         f_crc;
    bit         exp_bits[$];

    typedef struct {
        int          n;
        logic [31:0] d;
        logic [11:0] lb;
        logic [3:0]  last;
        bit          crc;
        int          nout;
        logic [31:0] o;
        logic [3:0]  p;
        int          lastbits;
        bit          ur;
    } vec_t;

    vec_t tv[5];

    function automatic vec_t mkv(int n, logic [31:0] d, logic [11:0] lb, logic [3:0] last,
                                 bit crc, int nout, logic [31:0] o, logic [3:0] p,
                                 int lastbits, bit ur);
        vec_t v;
        v.n = n; v.d = d; v.lb = lb; v.last = last; v.crc = crc;
        v.nout = nout; v.o = o; v.p = p; v.lastbits = lastbits; v.ur = ur;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input int idx);
        if (idx < f_n) begin
            tx_tvalid = 1'b1;
            tx_tdata  = f_data[idx];
            tx_tlast  = f_last[idx];
            tx_tlastb = f_lastb[idx];
            tx_tcrc   = f_crc;
        end else begin
            tx_tvalid = 1'b0;
            tx_tlast  = 1'b0;
            tx_tlastb = 3'd0;
        end
    endtask

    function automatic bit odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    function automatic void push_byte(input logic [7:0] b, input int nb);
        for (int j = 0; j < nb; j++) exp_bits.push_back(b[j]);
        if (nb == 8) exp_bits.push_back(odd_par(b));
    endfunction

    // Reference: air bit sequence after SOF, with byte-wise ISO 14443-3 CRC_A.
    function automatic void build_exp();
        logic [15:0] c;
        logic [7:0]  ch;
        int          nb;
        bit          full_last;
        exp_bits.delete();
        c = 16'h6363;
        for (int i = 0; i < f_n; i++) begin
            nb = (f_last[i] && f_lastb[i] != 3'd0) ? int'(f_lastb[i]) : 8;
            push_byte(f_data[i], nb);
            ch = f_data[i] ^ c[7:0];
            ch = ch ^ {ch[3:0], 4'b0000};
            c = (c >> 8) ^ ({8'h00, ch} << 8) ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
        end
        full_last = f_last[f_n-1] && (f_lastb[f_n-1] == 3'd0);
`ifdef NFCA_TX_CRC_EN
        if (f_crc && full_last) begin
            push_byte(c[7:0], 8);
            push_byte(c[15:8], 8);
        end
`else
        if (f_crc && full_last) c = 16'h0000;
`endif
    endfunction

    task automatic send_frame(input int pace, input bit exp_ur);
        int idx, k, cnt;
        bit acc, rq, fin;
        idx = 0; k = 0; cnt = 0; fin = 0;
        drive_byte(0);
        tx_req = 1'b0;
        while (!fin && cnt < 4000) begin
            acc = tx_tvalid & tx_tready;
            rq  = tx_req;
            tick();
            cnt++;
            if (acc) begin
                if (idx == 0) begin
                    chk("sof_en", tx_en, 1);
                    chk("sof_bit", tx_bit, 0);
                    chk("sof_busy", busy, 1);
                end
                idx++;
            end
            if (rq) begin
                if (k < exp_bits.size()) begin
                    chk("bit_en", tx_en, 1);
                    chk($sformatf("bit_val[%0d]", k), tx_bit, exp_bits[k]);
                end else begin
                    chk("eof_en", tx_en, 0);
                    chk("eof_bit", tx_bit, 0);
                    chk("eof_underrun", underrun, exp_ur);
                    fin = 1;
                end
                k++;
            end
            drive_byte(idx);
            tx_req = (idx > 0) && !fin && (cnt % pace == 0);
        end
        tx_req = 1'b0;
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL frame_end: got no EOF after %0d cycles, required within 4000", cnt);
        end
    endtask

    task automatic rx_window(input bit use_rx, input bit offer);
        int t;
        bit got;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        chk("rxwait_en", tx_en, 0);
        if (offer) drive_byte(0);
        else tx_tvalid = 1'b0;
        t = 0; got = 0;
        while (!got && t < int'(TMO) + 20) begin
            if (offer) chk("b2b_tready_low", tx_tready, 0);
            rx_on  = use_rx && t >= 3 && t < 8;
            tx_req = (t % 4 == 1);
            tick();
            t++;
            if (done) got = 1;
            else chk("rxwait_hold_en", tx_en, 0);
        end
        tx_req = 1'b0;
        rx_on  = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL rx_done: got no done in %0d cycles, required one", t);
        end else begin
            chk(use_rx ? "done_after_rx" : "done_timeout", t, use_rx ? 9 : int'(TMO));
            chk("done_busy", busy, 0);
            if (offer) chk("b2b_tready_high", tx_tready, 1);
            else begin
                tick();
                chk("done_pulse", done, 0);
            end
        end
    endtask

    task automatic load_vec(input vec_t v);
        f_n = v.n;
        f_crc = v.crc;
        for (int i = 0; i < v.n; i++) begin
            f_data[i]  = v.d[8*i +: 8];
            f_lastb[i] = v.lb[3*i +: 3];
            f_last[i]  = v.last[i];
        end
        exp_bits.delete();
        for (int j = 0; j < v.nout; j++)
            for (int b = 0; b < ((j == v.nout - 1) ? v.lastbits : 8); b++)
                exp_bits.push_back(v.o[8*j + b]);
        for (int j = 0; j < v.nout; j++) begin
            if (j < v.nout - 1 || v.lastbits == 8) begin
                // parity follows each full byte: insert after its 8 bits
                exp_bits.insert(9*j + 8, v.p[j]);
            end
        end
    endtask

    initial begin
        int seen_done, seen_en;
        tv[0] = mkv(1, 32'h26, 12'h007, 4'b0001, 0, 1, 32'h26, 4'b0000, 7, 0);
`ifdef NFCA_TX_CRC_EN
        tv[1] = mkv(2, 32'h0050, 12'h000, 4'b0010, 1, 4, 32'hCD570050, 4'b0011, 8, 0);
`else
        tv[1] = mkv(2, 32'h0050, 12'h000, 4'b0010, 1, 2, 32'h00000050, 4'b0011, 8, 0);
`endif
        tv[2] = mkv(2, 32'h3CA5, 12'h003, 4'b0010, 0, 2, 32'h3CA5, 4'b0011, 8, 0);
        tv[3] = mkv(3, 32'h0501FF, 12'h0C0, 4'b0100, 1, 3, 32'h0501FF, 4'b0001, 3, 0);
        tv[4] = mkv(1, 32'h81, 12'h000, 4'b0000, 0, 1, 32'h81, 4'b0001, 8, 1);

        tick();
        tick();
        chk("rst_tready", tx_tready, 0);
        chk("rst_en", tx_en, 0);
        chk("rst_bit", tx_bit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            load_vec(tv[i]);
            send_frame(5, tv[i].ur);
            rx_window(1, 0);
        end

        // Back-to-back: frame 2 offered during the RX window of frame 1.
        load_vec(tv[1]);
        send_frame(3, 0);
        load_vec(tv[0]);
        rx_window(1, 1);
        send_frame(4, 0);
        rx_window(0, 0);

        // Reset mid data: no done may follow.
        f_n = 2; f_crc = 0;
        f_data[0] = 8'hC3; f_data[1] = 8'h5A;
        f_lastb[0] = 3'd0; f_lastb[1] = 3'd0;
        f_last[0] = 0; f_last[1] = 1;
        drive_byte(0);
        tick();
        drive_byte(1);
        tx_req = 1'b1; tick(); tx_req = 1'b0; tick();
        tx_req = 1'b1; tick(); tx_req = 1'b0;
        chk("pre_rst_bit", tx_bit, 1);
        tx_tvalid = 1'b0;
        rstn = 1'b0;
        tick();
        chk("mid_rst_en", tx_en, 0);
        chk("mid_rst_bit", tx_bit, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_tready", tx_tready, 0);
        rstn = 1'b1;
        #1;
        chk("post_rst_tready", tx_tready, 1);
        seen_done = 0; seen_en = 0;
        for (int c = 0; c < 2 * int'(TMO); c++) begin
            tx_req = (c % 5 == 0);
            rx_on  = (c > 10 && c < 15);
            tick();
            if (done) seen_done++;
            if (tx_en) seen_en++;
        end
        tx_req = 1'b0;
        rx_on = 1'b0;
        chk("post_rst_no_done", seen_done, 0);
        chk("post_rst_no_en", seen_en, 0);

        // Randomised frames against the model.
        for (int r = 0; r < 25; r++) begin
            f_n = $urandom_range(1, 4);
            f_crc = $urandom_range(0, 1);
            for (int i = 0; i < f_n; i++) begin
                f_data[i]  = 8'($urandom);
                f_last[i]  = (i == f_n - 1);
                f_lastb[i] = 3'($urandom);
            end
            if ($urandom_range(0, 1) == 0) f_lastb[f_n-1] = 3'd0;
            build_exp();
            send_frame($urandom_range(2, 9), 0);
            rx_window($urandom_range(0, 3) != 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
